// File: rtl/fft_pkg.sv
// Shared definitions for the 64-point FFT output path: transform size,
// complex word width, output sequencer states and the address bit-reverser.
package fft_pkg;

   localparam int FFT_N     = 64;
   localparam int FFT_LOG2N = 6;
   localparam int CPLX_W    = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } SeqState;

   // Mirror the six address bits so natural bin k maps to its radix-2 storage slot
   function automatic logic [FFT_LOG2N-1:0] bitrev6(input logic [FFT_LOG2N-1:0] i_addr);
      logic [FFT_LOG2N-1:0] w_rev;
      w_rev = '0;
      for (int k = 0; k < FFT_LOG2N; k++) begin
         w_rev[k] = i_addr[FFT_LOG2N-1-k];
      end
      return w_rev;
   endfunction

endpackage

// File: rtl/fifo2_sync.sv
// Two-entry synchronous FIFO with occupancy count. The head entry is always
// presented on o_rdData; the owner must only pop when o_count is non-zero and
// only push when there is room.
module fifo2_sync #(
   parameter int WIDTH = 38
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             i_wrEn,
   input  logic [WIDTH-1:0] i_wrData,
   input  logic             i_rdEn,
   output logic [WIDTH-1:0] o_rdData,
   output logic [1:0]       o_count
);

   logic [WIDTH-1:0] r_mem [2];
   logic             r_wrPtr;
   logic             r_rdPtr;
   logic [1:0]       r_count;

   // Storage, pointers and count; a simultaneous push and pop keeps the count
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wrPtr  <= 1'b0;
         r_rdPtr  <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (i_wrEn) begin
            r_mem[r_wrPtr] <= i_wrData;
            r_wrPtr        <= ~r_wrPtr;
         end
         if (i_rdEn) begin
            r_rdPtr <= ~r_rdPtr;
         end
         case ({i_wrEn, i_rdEn})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_rdData = r_mem[r_rdPtr];
   assign o_count  = r_count;

endmodule

// File: rtl/fft_out_sequencer.sv
// Output-stage controller of the 64-point FFT: reads the result RAM in
// (optionally) bit-reversed order, selects the 1/64 scaling path for inverse
// transforms and streams the words out over valid/ready through a 2-entry
// buffer. Reads are credit-limited so the buffer can never overflow.
module fft_out_sequencer
   import fft_pkg::*;
#(
   parameter bit BIT_REVERSE = 1'b1
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic                 Start,
   input  logic                 Ifft_Mode,
   output logic                 Busy,
   output logic                 Ram_Rd_En,
   output logic [FFT_LOG2N-1:0] Ram_Rd_Addr,
   output logic                 Swap,
   input  logic [CPLX_W-1:0]    Scaled_Data,
   output logic [CPLX_W-1:0]    Out_Data,
   output logic [FFT_LOG2N-1:0] Out_Index,
   output logic                 Out_Valid,
   output logic                 Out_Last,
   input  logic                 Out_Ready,
   output logic                 Done
);

   localparam int ENTRY_W = CPLX_W + FFT_LOG2N;

   SeqState              r_state;
   SeqState              w_nextState;
   logic [FFT_LOG2N:0]   r_rdIdx;
   logic                 r_inflight;
   logic [FFT_LOG2N-1:0] r_inflightIdx;
   logic                 r_swap;
   logic                 r_done;

   logic                 w_issue;
   logic                 w_pop;
   logic                 w_accept;
   logic                 w_valid;
   logic                 w_headLast;
   logic [2:0]           w_credit;
   logic [1:0]           w_count;
   logic [ENTRY_W-1:0]   w_head;
   logic [FFT_LOG2N-1:0] w_headIdx;
   logic [FFT_LOG2N-1:0] w_rdAddr;

   assign w_valid    = (w_count != 2'd0);
   assign w_pop      = w_valid & Out_Ready;
   assign w_accept   = (r_state == ST_IDLE) & Start;
   assign w_headIdx  = w_head[FFT_LOG2N-1:0];
   assign w_headLast = (w_headIdx == FFT_LOG2N'(FFT_N - 1));
   assign w_credit   = {1'b0, w_count} + {2'b00, r_inflight};
   assign w_rdAddr   = BIT_REVERSE ? bitrev6(r_rdIdx[FFT_LOG2N-1:0]) : r_rdIdx[FFT_LOG2N-1:0];

   // State register
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state and read issue: a read goes out only if buffered + in-flight
   // words, less the one leaving this cycle, still leave a free slot
   always_comb begin
      w_nextState = r_state;
      w_issue     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (Start) begin
               w_nextState = ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_credit < (3'd2 + {2'b00, w_pop})) begin
               w_issue = 1'b1;
               if (r_rdIdx == 7'(FFT_N - 1)) begin
                  w_nextState = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (r_done) begin
               w_nextState = ST_IDLE;
            end
         end
         default: w_nextState = ST_IDLE;
      endcase
   end

   // Frame bookkeeping: read counter, scaling select, in-flight tag and Done
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_rdIdx       <= '0;
         r_swap        <= 1'b0;
         r_inflight    <= 1'b0;
         r_inflightIdx <= '0;
         r_done        <= 1'b0;
      end else begin
         if (w_accept) begin
            r_rdIdx <= '0;
            r_swap  <= Ifft_Mode;
         end else if (w_issue) begin
            r_rdIdx <= r_rdIdx + 7'd1;
         end
         r_inflight    <= w_issue;
         r_inflightIdx <= r_rdIdx[FFT_LOG2N-1:0];
         r_done        <= (r_state == ST_DRAIN) & w_pop & w_headLast;
      end
   end

   fifo2_sync #(
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .i_wrEn   (r_inflight),
      .i_wrData ({Scaled_Data, r_inflightIdx}),
      .i_rdEn   (w_pop),
      .o_rdData (w_head),
      .o_count  (w_count)
   );

   assign Busy        = (r_state != ST_IDLE);
   assign Ram_Rd_En   = w_issue;
   assign Ram_Rd_Addr = w_issue ? w_rdAddr : '0;
   assign Swap        = r_swap;
   assign Out_Valid   = w_valid;
   assign Out_Data    = w_valid ? w_head[ENTRY_W-1:FFT_LOG2N] : '0;
   assign Out_Index   = w_valid ? w_headIdx : '0;
   assign Out_Last    = w_valid & w_headLast;
   assign Done        = r_done;

endmodule

// File: tb/tb_fft_out_sequencer.sv
// Self-checking bench for fft_out_sequencer. A RAM+scaler model answers reads;
// a reference model tracks which bin must come out next and what it must hold.
module tb_fft_out_sequencer;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        Start;
   logic        Ifft_Mode;
   logic        Out_Ready;
   logic [31:0] Scaled_Data = '0;
   logic        Busy, Ram_Rd_En, Swap, Out_Valid, Out_Last, Done;
   logic [5:0]  Ram_Rd_Addr, Out_Index;
   logic [31:0] Out_Data;

   logic        nStart, nIfftMode, nOutReady;
   logic [31:0] nScaledData = '0;
   logic        nBusy, nRamRdEn, nSwap, nOutValid, nOutLast, nDone;
   logic [5:0]  nRamRdAddr, nOutIndex;
   logic [31:0] nOutData;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int expIdx = 0;
   int rdExp = 0;
   int doneCount = 0;
   bit expSwap = 1'b0;
   bit checkEn = 1'b0;
   bit prevStall = 1'b0;

   always #5 Clk = ~Clk;

   fft_out_sequencer #(.BIT_REVERSE(1'b1)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Ifft_Mode(Ifft_Mode), .Busy(Busy),
      .Ram_Rd_En(Ram_Rd_En), .Ram_Rd_Addr(Ram_Rd_Addr), .Swap(Swap),
      .Scaled_Data(Scaled_Data), .Out_Data(Out_Data), .Out_Index(Out_Index),
      .Out_Valid(Out_Valid), .Out_Last(Out_Last), .Out_Ready(Out_Ready), .Done(Done)
   );

   fft_out_sequencer #(.BIT_REVERSE(1'b0)) dutNat (
      .Clk(Clk), .Rst_n(Rst_n), .Start(nStart), .Ifft_Mode(nIfftMode), .Busy(nBusy),
      .Ram_Rd_En(nRamRdEn), .Ram_Rd_Addr(nRamRdAddr), .Swap(nSwap),
      .Scaled_Data(nScaledData), .Out_Data(nOutData), .Out_Index(nOutIndex),
      .Out_Valid(nOutValid), .Out_Last(nOutLast), .Out_Ready(nOutReady), .Done(nDone)
   );

   // Reverse the six index bits by explicit reordering
   function automatic logic [5:0] bitrevTb(input int x);
      logic [5:0] v;
      v = x[5:0];
      return {v[0], v[1], v[2], v[3], v[4], v[5]};
   endfunction

   // RAM holds {a, ~a} at address a; the scaled path divides the word by 64
   function automatic logic [31:0] ramWord(input logic [5:0] a, input logic sw);
      logic [15:0] h;
      h = {10'd0, a};
      return sw ? ({h, ~h} >> 6) : {h, ~h};
   endfunction

   // Word expected for output bin idx
   function automatic logic [31:0] expWord(input int idx, input logic sw);
      return ramWord(bitrevTb(idx), sw);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic toCycle(input int c);
      while (cyc < c) begin
         @(posedge Clk);
         #1;
         cyc++;
      end
   endtask

   // Pulse Start for one cycle; returns one cycle after acceptance (cycle 1)
   task automatic applyStimulus(input bit mode);
      @(posedge Clk);
      #1;
      expIdx    = 0;
      rdExp     = 0;
      doneCount = 0;
      expSwap   = mode;
      prevStall = 1'b0;
      checkEn   = 1'b1;
      Start     = 1'b1;
      Ifft_Mode = mode;
      Out_Ready = 1'b1;
      cyc       = 0;
      toCycle(1);
      Start = 1'b0;
   endtask

   // Wait (bounded) for Done and check frame completion
   task automatic finishFrame(input int expDone, input bit startAtDone);
      int got;
      got = -1;
      while (cyc < 400 && got < 0) begin
         if (Done) got = cyc;
         else toCycle(cyc + 1);
      end
      checkOutput("doneSeen", (got >= 0), 1'b1);
      if (expDone >= 0) checkOutput("doneCycle", got, expDone);
      if (got >= 0) begin
         checkOutput("busyAtDone", Busy, 1'b1);
         if (startAtDone) Start = 1'b1;
         toCycle(cyc + 1);
         Start = 1'b0;
         checkOutput("busyFall", Busy, 1'b0);
         checkOutput("donePulse", Done, 1'b0);
         toCycle(cyc + 1);
         checkOutput("noRestart", Busy, 1'b0);
      end
      checkOutput("wordCount", expIdx, 64);
      checkOutput("doneCount", doneCount, 1);
   endtask

   // RAM plus scaling stage for both instances: data appears the cycle after a read
   always @(posedge Clk) begin
      if (Ram_Rd_En) Scaled_Data <= ramWord(Ram_Rd_Addr, Swap);
      if (nRamRdEn) nScaledData <= ramWord(nRamRdAddr, nSwap);
   end

   // Per-cycle comparison of the main instance against the reference model
   always @(negedge Clk) begin
      int outstanding;
      bit pop;
      if (checkEn && Rst_n) begin
         if (Ram_Rd_En) begin
            checkOutput("rdAddr", Ram_Rd_Addr, bitrevTb(rdExp));
            rdExp++;
         end
         if (Out_Valid) begin
            checkOutput("outIndex", Out_Index, expIdx);
            checkOutput("outData", Out_Data, expWord(expIdx, expSwap));
            checkOutput("outLast", Out_Last, (expIdx == 63));
         end
         if (prevStall) checkOutput("validHeld", Out_Valid, 1'b1);
         if (Busy) checkOutput("swapConst", Swap, expSwap);
         pop = Out_Valid && Out_Ready;
         outstanding = rdExp - expIdx - (pop ? 1 : 0);
         checkOutput("outstanding", (outstanding <= 2), 1'b1);
         if (pop) expIdx++;
         prevStall = Out_Valid && !Out_Ready;
         if (Done) begin
            checkOutput("doneAfterLast", expIdx, 64);
            doneCount++;
         end
      end
   end

   initial begin
      #50000;
      $display("[TB] FAIL watchdog expired actual=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      Rst_n = 1'b0; Start = 1'b0; Ifft_Mode = 1'b0; Out_Ready = 1'b1;
      nStart = 1'b0; nIfftMode = 1'b0; nOutReady = 1'b1;
      #2;
      checkOutput("rstBusy", Busy, 1'b0);
      checkOutput("rstRdEn", Ram_Rd_En, 1'b0);
      checkOutput("rstAddr", Ram_Rd_Addr, 6'd0);
      checkOutput("rstSwap", Swap, 1'b0);
      checkOutput("rstValid", Out_Valid, 1'b0);
      checkOutput("rstLast", Out_Last, 1'b0);
      checkOutput("rstData", Out_Data, 32'd0);
      checkOutput("rstIndex", Out_Index, 6'd0);
      checkOutput("rstDone", Done, 1'b0);
      repeat (2) @(posedge Clk);
      #1 Rst_n = 1'b1;

      // FFT mode, consumer always ready
      applyStimulus(1'b0);
      checkOutput("t1Busy1", Busy, 1'b1);
      checkOutput("t1RdEn1", Ram_Rd_En, 1'b1);
      checkOutput("t1Addr1", Ram_Rd_Addr, 6'd0);
      toCycle(2);
      checkOutput("t1Addr2", Ram_Rd_Addr, 6'd32);
      checkOutput("t1Valid2", Out_Valid, 1'b0);
      toCycle(3);
      checkOutput("t1Valid3", Out_Valid, 1'b1);
      checkOutput("t1Data0", Out_Data, 32'h0000FFFF);
      toCycle(4);
      checkOutput("t1Idx1", Out_Index, 6'd1);
      checkOutput("t1Data1", Out_Data, 32'h0020FFDF);
      toCycle(66);
      checkOutput("t1Last", Out_Last, 1'b1);
      checkOutput("t1IdxLast", Out_Index, 6'd63);
      checkOutput("t1DataLast", Out_Data, 32'h003FFFC0);
      finishFrame(67, 1'b0);

      // IFFT mode with ignored Start pulses and Ifft_Mode toggles mid-frame
      applyStimulus(1'b1);
      checkOutput("t2Swap", Swap, 1'b1);
      toCycle(3);
      checkOutput("t2Data0", Out_Data, 32'h000003FF);
      toCycle(4);
      checkOutput("t2Data1", Out_Data, 32'h000083FF);
      toCycle(5);  Start = 1'b1; Ifft_Mode = 1'b0;
      toCycle(6);  Start = 1'b0;
      toCycle(20); Ifft_Mode = 1'b1;
      toCycle(30); Ifft_Mode = 1'b0;
      toCycle(40); Start = 1'b1;
      toCycle(41); Start = 1'b0;
      checkOutput("t2SwapHeld", Swap, 1'b1);
      toCycle(66);
      checkOutput("t2DataLast", Out_Data, 32'h0000FFFF);
      finishFrame(67, 1'b1);

      // Five-cycle stall delays Done by five cycles
      applyStimulus(1'b0);
      toCycle(10); Out_Ready = 1'b0;
      toCycle(12);
      checkOutput("t3StallIdx", Out_Index, 6'd7);
      checkOutput("t3StallValid", Out_Valid, 1'b1);
      toCycle(15); Out_Ready = 1'b1;
      finishFrame(72, 1'b0);

      // Random backpressure, then a long stall
      applyStimulus(1'b0);
      for (int i = 0; i < 60; i++) begin
         Out_Ready = 1'($urandom_range(0, 1));
         toCycle(cyc + 1);
      end
      Out_Ready = 1'b0;
      toCycle(cyc + 10);
      checkOutput("t4FullValid", Out_Valid, 1'b1);
      checkOutput("t4NoRead", Ram_Rd_En, 1'b0);
      Out_Ready = 1'b1;
      finishFrame(-1, 1'b0);

      // Reset in the middle of an IFFT frame, then a clean frame
      applyStimulus(1'b1);
      toCycle(20);
      checkEn = 1'b0;
      Rst_n = 1'b0;
      #1;
      checkOutput("t5Valid", Out_Valid, 1'b0);
      checkOutput("t5Busy", Busy, 1'b0);
      checkOutput("t5Swap", Swap, 1'b0);
      checkOutput("t5Done", Done, 1'b0);
      checkOutput("t5RdEn", Ram_Rd_En, 1'b0);
      repeat (2) @(posedge Clk);
      #1 Rst_n = 1'b1;
      applyStimulus(1'b0);
      toCycle(3);
      checkOutput("t5Idx0", Out_Index, 6'd0);
      checkOutput("t5Data0", Out_Data, 32'h0000FFFF);
      finishFrame(67, 1'b0);

      // Natural-order instance
      @(posedge Clk);
      #1 nStart = 1'b1;
      cyc = 0;
      toCycle(1);
      nStart = 1'b0;
      for (int i = 0; i < 64; i++) begin
         toCycle(1 + i);
         checkOutput("natRdEn", nRamRdEn, 1'b1);
         checkOutput("natAddr", nRamRdAddr, i);
      end
      checkOutput("natIdx", nOutIndex, 6'd61);
      checkOutput("natData", nOutData, 32'h003DFFC2);
      toCycle(65);
      checkOutput("natRdStop", nRamRdEn, 1'b0);
      toCycle(67);
      checkOutput("natDone", nDone, 1'b1);
      toCycle(68);
      checkOutput("natBusyFall", nBusy, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fft_out_sequencer.md
# fft_out_sequencer

Output-stage controller for the 64-point FFT processor. After the butterfly core signals frame completion, it reads the 64 complex results from the result RAM in bit-reversed address order. It drives the `Swap` select of the output scaling stage, which scales by 1/64 in IFFT mode. It streams the scaled words to the downstream consumer over a valid/ready handshake, with a 2-entry buffer that absorbs RAM read latency and backpressure.

## Interface
Parameters:
- `BIT_REVERSE`, 1: 1 = read address is the bit-reverse of the output index; 0 = natural order.

Ports:
- `Clk`, in, 1: single clock; all logic is rising-edge.
- `Rst_n`, in, 1: asynchronous, active-low reset.
- `Start`, in, 1: frame-complete pulse from the FFT core; sampled only in IDLE.
- `Ifft_Mode`, in, 1: sampled together with `Start`; 1 = inverse transform, so scaling is applied.
- `Busy`, out, 1: high from the accepted `Start` until `Done`, inclusive.
- `Ram_Rd_En`, out, 1: result RAM read strobe.
- `Ram_Rd_Addr`, out, 6: result RAM read address.
- `Swap`, out, 1: select of the output scaling stage; 1 = scaled path.
- `Scaled_Data`, in, 32: scaling-stage output. Real part is [31:16], imag part is [15:0]. Valid the cycle after `Ram_Rd_En`.
- `Out_Data`, out, 32: streamed result.
- `Out_Index`, out, 6: natural-order output index (bin number) of `Out_Data`.
- `Out_Valid`, out, 1: `Out_Data` is valid.
- `Out_Last`, out, 1: high with the word whose `Out_Index` is 63.
- `Out_Ready`, in, 1: consumer accepts the word.
- `Done`, out, 1: one-cycle pulse after the last word is accepted.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE to RUN on `Start`=1. In that cycle `Ifft_Mode` is latched into `Swap`, and the read counter `rd_idx` and output counter are cleared.
- RUN: a read is issued when `occupancy + inflight - pop < 2`. Here `pop` = `Out_Valid & Out_Ready` in the current cycle.
  - On issue: `Ram_Rd_En`=1 and `Ram_Rd_Addr` = bitrev(`rd_idx`), or `rd_idx` when `BIT_REVERSE`=0. Then `rd_idx` increments.
  - After the issue with `rd_idx`=63, go to DRAIN.
- DRAIN: no reads. When the word with `Out_Index`=63 is accepted, pulse `Done` next cycle and return to IDLE.
- Buffer: a 2-entry FIFO of {data, index}.
  - `Scaled_Data` is written one cycle after each read.
  - The head drives `Out_Data`, `Out_Index` and `Out_Last`.
  - Simultaneous write and pop is allowed and leaves occupancy unchanged.
  - The buffer never overflows, because the credit rule guarantees it.
- `Swap` stays constant for the whole frame. Changes on `Ifft_Mode` while `Busy`=1 are ignored.
- `Start` while `Busy`=1 is ignored. `Start` in the same cycle as `Done` is also ignored; IDLE is entered first.
- Handshake rules:
  - `Out_Data`, `Out_Index` and `Out_Last` are held stable while `Out_Valid`=1 and `Out_Ready`=0.
  - `Out_Valid` never drops without a pop.
- `rd_idx` is 7 bits wide so that 64 is terminal. The address never wraps within a frame.

## Timing
- Reset values: `Busy`, `Ram_Rd_En`, `Swap`, `Out_Valid`, `Out_Last` and `Done` are 0. `Ram_Rd_Addr`, `Out_Data` and `Out_Index` are 0. State = IDLE, FIFO empty.
- When `Start` is accepted at cycle 0:
  - `Busy`=1 from cycle 1.
  - First `Ram_Rd_En` at cycle 1.
  - First `Out_Valid` at cycle 3.
- With `Out_Ready` held at 1: one word per cycle, last word at cycle 66, `Done` at cycle 67, `Busy` falls at cycle 68.
- A backpressure stall of N cycles delays `Done` by exactly N cycles.
- Reset asserted mid-frame: all outputs return to reset values immediately. `Done` is not pulsed, and the partial frame is discarded.

## Structure
- Shared package `fft_pkg`: `FFT_N`=64, `FFT_LOG2N`=6, `CPLX_W`=32, the state enum, and a `bitrev6` function.
- One natural sub-module, `fifo2_sync`: a 2-entry synchronous FIFO, parameterised in width, with count output.
- The scaling stage stays outside this block. This block only drives `Swap` and consumes `Scaled_Data`.

## Test plan
- Bench model: the RAM returns address `a` as `{a, ~a}` (16 bits each); the scaling stage is modelled as a right shift by 6 when `Swap`=1.
- FFT mode, `Out_Ready`=1: `Start` at cycle 0 → `Ram_Rd_Addr` sequence 0, 32, 16, 48, …, 63. `Out_Index` runs 0 to 63. `Out_Data`[31:16] = bitrev(`Out_Index`). `Out_Last` with index 63, `Done` at cycle 67.
- IFFT mode: `Ifft_Mode`=1 at `Start` → `Swap`=1 for the whole frame and every word is shifted right by 6. Toggling `Ifft_Mode` mid-frame leaves `Swap` unchanged.
- Backpressure: `Out_Ready` is random at 50%, then low for 10 cycles → no lost or duplicated index, data stable while stalled, at most 2 reads outstanding plus buffered at any time.
- `Start` pulsed at cycles 5 and 40 during a frame → ignored, exactly 64 words and one `Done`.
- `Rst_n` low at cycle 20 → `Out_Valid`, `Busy` and `Swap` go to 0 asynchronously. A new `Start` after release yields a full frame beginning at index 0.
- `BIT_REVERSE`=0: `Ram_Rd_Addr` = 0, 1, 2, …, 63.
